// File: rtl/alu_mdu_seq_if.sv
// Handshake bundle between EX control and the alu_mdu_seq execute unit.
// The unit itself connects through the slave modport.
interface alu_mdu_seq_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_busy;

  modport master (output flush, in_valid, in_op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_result, out_busy);
  modport slave  (input  flush, in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_result, out_busy);
endinterface

// File: rtl/alu_mdu_seq.sv
// EX-stage execute unit: single-cycle ALU plus iterative RV-M multiply/divide.
// The multiply/divide datapath and BUSY state exist only when ALU_MDU_EN is defined.
module alu_mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_mdu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nx;
  logic            accept, is_m, mdu_last;
  logic [XLEN-1:0] alu_res, mdu_res, res;
  logic [SHW-1:0]  sh;

  assign sh     = bus.in_b[SHW-1:0];
  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    alu_res = '0;
    case (bus.in_op)
      5'd0:  alu_res = bus.in_a & bus.in_b;
      5'd1:  alu_res = bus.in_a | bus.in_b;
      5'd2:  alu_res = bus.in_a + bus.in_b;
      5'd3:  alu_res = bus.in_a - bus.in_b;
      5'd4:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      5'd5:  alu_res = {{(XLEN-1){1'b0}}, bus.in_a < bus.in_b};
      5'd6:  alu_res = bus.in_a ^ bus.in_b;
      5'd8:  alu_res = bus.in_a << sh;
      5'd9:  alu_res = $signed(bus.in_a) >>> sh;
      5'd10: alu_res = bus.in_a >> sh;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MDU_EN
  logic [XLEN-1:0]   acc, mq, opnd, acc_n, mq_n, ma, mb, q_f, r_f;
  logic [SHW-1:0]    cnt;
  logic [2:0]        mop;
  logic              neg_q, neg_r, dz, a_sg, b_sg, sa, sb;
  logic [XLEN:0]     sum, shv, dif;
  logic [2*XLEN-1:0] prod;

  assign is_m     = (bus.in_op[4:3] == 2'b10);
  assign mdu_last = (state == BUSY) && (cnt == SHW'(XLEN-1));

  // Both engines run on magnitudes; signs are reapplied on the final iteration.
  always_comb begin
    a_sg = (bus.in_op[2:0] == 3'd1) | (bus.in_op[2:0] == 3'd2) |
           (bus.in_op[2:0] == 3'd4) | (bus.in_op[2:0] == 3'd6);
    b_sg = (bus.in_op[2:0] == 3'd1) | (bus.in_op[2:0] == 3'd4) |
           (bus.in_op[2:0] == 3'd6);
    sa   = a_sg & bus.in_a[XLEN-1];
    sb   = b_sg & bus.in_b[XLEN-1];
    ma   = sa ? -bus.in_a : bus.in_a;
    mb   = sb ? -bus.in_b : bus.in_b;
  end

  // {acc,mq} is the shifting product (multiply) or remainder:quotient (divide).
  always_comb begin
    sum = {1'b0, acc} + {1'b0, (mq[0] ? opnd : {XLEN{1'b0}})};
    shv = {acc, mq[XLEN-1]};
    dif = shv - {1'b0, opnd};
    if (mop[2]) begin
      if (dif[XLEN]) begin
        acc_n = shv[XLEN-1:0];
        mq_n  = {mq[XLEN-2:0], 1'b0};
      end else begin
        acc_n = dif[XLEN-1:0];
        mq_n  = {mq[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_n = sum[XLEN:1];
      mq_n  = {sum[0], mq[XLEN-1:1]};
    end
    prod = {acc_n, mq_n};
    if (neg_q) prod = -prod;
    q_f = neg_q ? -mq_n : mq_n;
    r_f = neg_r ? -acc_n : acc_n;
    case (mop)
      3'd0:                mdu_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    mdu_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          mdu_res = dz ? {XLEN{1'b1}} : q_f;
      default:             mdu_res = r_f;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; mq <= '0; opnd <= '0; cnt <= '0;
      mop <= '0; neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
    end else if (accept && is_m) begin
      acc   <= '0;
      mq    <= ma;
      opnd  <= mb;
      cnt   <= '0;
      mop   <= bus.in_op[2:0];
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= (bus.in_b == '0);
    end else if (state == BUSY) begin
      acc <= acc_n;
      mq  <= mq_n;
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign is_m     = 1'b0;
  assign mdu_last = 1'b0;
  assign mdu_res  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_m ? BUSY : DONE;
`ifdef ALU_MDU_EN
      BUSY: if (mdu_last) state_nx = DONE;
`endif
      DONE: begin
        if (accept)             state_nx = is_m ? BUSY : DONE;
        else if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_comb begin
    bus.in_ready  = ~bus.flush & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    bus.out_valid = (state == DONE);
`ifdef ALU_MDU_EN
    bus.out_busy  = (state == BUSY);
`else
    bus.out_busy  = 1'b0;
`endif
  end

  // Result only moves on an accept or MDU completion, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 res <= '0;
    else if (accept && !is_m) res <= alu_res;
    else if (mdu_last)       res <= mdu_res;
  end

  assign bus.out_result = res;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq (XLEN=32); MDU checks run when ALU_MDU_EN is defined.
module tb_alu_mdu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_seq_if #(.XLEN(32)) bus ();
  alu_mdu_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [4:0] AND_ = 5'd0, OR_ = 5'd1, ADD = 5'd2, SUB = 5'd3, SLT = 5'd4,
                         SLTU = 5'd5, XOR_ = 5'd6, SLL = 5'd8, SRA = 5'd9, SRL = 5'd10,
                         MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19,
                         DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          busy;
    int          acc;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, busy_run = 0;
  bit          seen = 0, mon_off = 0;
  logic [31:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int busy,
                       input bit push, input string nm);
    int w = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    #1;
    while (!bus.in_ready && w < 200) begin @(negedge clk); #1; w++; end
    if (!bus.in_ready) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      if (push) sb.push_back('{exp: exp, lat: lat, busy: busy, acc: cyc, nm: nm});
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  always begin
    @(negedge clk); #2;
    if (!rst && !mon_off) begin
      if (bus.out_busy) busy_run++;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", bus.out_result, 32'hxxxxxxxx);
        end else begin
          if (!seen) begin
            seen = 1; held = bus.out_result;
            chk({sb[0].nm, "_lat"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          end else chk({sb[0].nm, "_hold"}, bus.out_result, held);
          if (bus.out_ready) begin
            chk(sb[0].nm, bus.out_result, sb[0].exp);
            if (sb[0].busy >= 0) chk({sb[0].nm, "_busy"}, 32'(busy_run), 32'(sb[0].busy));
            busy_run = 0; seen = 0;
            sb.delete(0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_busy", {31'd0, bus.out_busy}, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    rst = 0;
    #1 chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ALU sweep, back-to-back with out_ready held high
    issue(ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, 1, "add_ovf");
    issue(SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 0, 1, "slt");
    issue(SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 1, "sltu");
    issue(SRA, 32'h80000000, 32'h24, 32'hF8000000, 1, 0, 1, "sra");
    issue(SRL, 32'h80000000, 32'h24, 32'h08000000, 1, 0, 1, "srl");
    issue(SLL, 32'h00000003, 32'h21, 32'h00000006, 1, 0, 1, "sll");
    issue(SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1, 0, 1, "sub");
    issue(AND_, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1, 0, 1, "and");
    issue(OR_, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1, 0, 1, "or");
    issue(XOR_, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1, 0, 1, "xor");
    issue(5'd7, 32'h12345678, 32'h1, 32'h0, 1, 0, 1, "undef_op");

    // Stall: result held, in_ready low
    drain();
    bus.out_ready = 0;
    issue(ADD, 32'd1, 32'd2, 32'd3, 1, 0, 1, "hold_add");
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1;

    // Flush of a held result, with a competing offer in the same cycle
    drain();
    bus.out_ready = 0; mon_off = 1;
    issue(ADD, 32'd4, 32'd5, 32'd9, 1, 0, 0, "flushed_add");
    @(negedge clk);
    bus.flush = 1; bus.out_ready = 1;
    bus.in_valid = 1; bus.in_op = ADD; bus.in_a = 32'd6; bus.in_b = 32'd6;
    #1 chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    chk("flush_done_valid", {31'd0, bus.out_valid}, 32'd0);
    mon_off = 0;
    issue(ADD, 32'd2, 32'd3, 32'd5, 1, 0, 1, "post_flush_add");

`ifdef ALU_MDU_EN
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, 1, "mulhu");
    issue(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33, 32, 1, "mulh");
    issue(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, 32, 1, "mul");
    issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32, 1, "mulhsu");
    issue(MUL, 32'd3, 32'd4, 32'd12, 33, 32, 1, "mul_small");
    issue(DIV, 32'd7, 32'd0, 32'hFFFFFFFF, 33, 32, 1, "div_by0");
    issue(REMU, 32'd7, 32'd0, 32'd7, 33, 32, 1, "remu_by0");
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 32, 1, "div_ovf");
    issue(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33, 32, 1, "rem_ovf");
    issue(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 32, 1, "div_neg");
    issue(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 32, 1, "rem_neg");
    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 32, 1, "divu");
    issue(REMU, 32'd100, 32'd7, 32'd2, 33, 32, 1, "remu");

    // Flush at BUSY cycle 10; the divide result must never appear
    drain();
    issue(DIV, 32'd100, 32'd7, 32'd14, 33, 32, 0, "flushed_div");
    repeat (10) @(negedge clk);
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    chk("flush_busy", {31'd0, bus.out_busy}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    issue(ADD, 32'd2, 32'd3, 32'd5, 1, -1, 1, "add_after_busy_flush");

    // Asynchronous reset in the middle of a divide
    drain();
    issue(DIV, 32'd100, 32'd7, 32'd14, 33, 32, 0, "reset_div");
    repeat (5) @(negedge clk);
    #1 chk("pre_rst_busy", {31'd0, bus.out_busy}, 32'd1);
    rst = 1;
    #1;
    chk("async_rst_busy", {31'd0, bus.out_busy}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_result", bus.out_result, 32'd0);
    @(negedge clk);
    rst = 0; busy_run = 0;
    issue(ADD, 32'd9, 32'd1, 32'd10, 1, -1, 1, "add_after_rst");
`else
    issue(MUL, 32'd3, 32'd4, 32'd0, 1, 0, 1, "mul_disabled");
    issue(DIV, 32'd7, 32'd0, 32'd0, 1, 0, 1, "div_disabled");
`endif

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
